// File: rtl/count_scheduler_pkg.sv
// Shared types and constants for the two-requester count scheduler.
package count_scheduler_pkg;

  localparam int DEF_W = 4;
  localparam int N_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/count_scheduler_cnt_core.sv
// W-bit up counter with synchronous clear (dominant) and count enable.
module cnt_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/count_scheduler.sv
// Round-robin scheduler granting a shared counter to one of two requesters
// for a run of target+1 cycles; runs are non-preemptive but abortable.
//
// Handshake: req is a level request; a grant is visible on gnt one cycle after
// the IDLE edge that saw req, and the run ends with a one-cycle done pulse
// (normal completion) or silently on abort. req need not be held during RUN.
module count_scheduler
  import count_scheduler_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     len0,
  input  logic [W-1:0]     len1,
  input  logic             abort,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             enable,
  output logic [W-1:0]     count,
  output logic [N_REQ-1:0] done,
  output state_t           dbg_state
);

  state_t       r_state;
  state_t       w_next;
  logic         r_owner;
  logic         r_last;
  logic [W-1:0] r_target;
  logic [W-1:0] w_count;
  logic         w_winner;
  logic         w_at_target;
  logic         w_clr;
  logic         w_cnt_en;

  // r_last holds the last-served requester; resetting it to 1 favours requester 0.
  always_comb begin
    w_winner = 1'b0;
    if (req == 2'b10) begin
      w_winner = 1'b1;
    end else if (req == 2'b11) begin
      w_winner = ~r_last;
    end
  end

  assign w_at_target = (w_count == r_target);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_target <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && req != 2'b00) begin
        r_owner  <= w_winner;
        r_last   <= w_winner;
        r_target <= w_winner ? len1 : len0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req != 2'b00) w_next = ST_RUN;
      ST_RUN: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_at_target) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt       = 2'b00;
    busy      = 1'b0;
    enable    = 1'b0;
    done      = 2'b00;
    dbg_state = r_state;
    case (r_state)
      ST_RUN: begin
        gnt    = r_owner ? 2'b10 : 2'b01;
        busy   = 1'b1;
        enable = 1'b1;
      end
      ST_DONE: done = r_owner ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  // Count is zero whenever we are not in RUN, except in DONE where the
  // final value holds for its single cycle and clears on the way to IDLE.
  assign w_clr    = reset || (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                    (r_state == ST_RUN && abort);
  assign w_cnt_en = (r_state == ST_RUN) && !w_at_target;

  cnt_core #(.W(W)) u_cnt_core (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_en    (w_cnt_en),
    .o_count (w_count)
  );

  assign count = w_count;

endmodule

// File: tb/tb_count_scheduler.sv
// Directed bench for count_scheduler: single runs, contention, boundaries,
// abort, reset mid-run and target stability, with hand-computed expectations.
module tb_count_scheduler;
  import count_scheduler_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [1:0]   req;
  logic [W-1:0] len0;
  logic [W-1:0] len1;
  logic         abort;
  logic [1:0]   gnt;
  logic         busy;
  logic         enable;
  logic [W-1:0] count;
  logic [1:0]   done;
  state_t       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  count_scheduler #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .len0      (len0),
    .len1      (len1),
    .abort     (abort),
    .gnt       (gnt),
    .busy      (busy),
    .enable    (enable),
    .count     (count),
    .done      (done),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1ns after it and inputs change there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_gnt, input logic e_busy,
                         input logic e_en, input logic [W-1:0] e_cnt, input logic [1:0] e_done);
    chk({tag, ".gnt"},   32'(gnt),    32'(e_gnt));
    chk({tag, ".busy"},  32'(busy),   32'(e_busy));
    chk({tag, ".en"},    32'(enable), 32'(e_en));
    chk({tag, ".count"}, 32'(count),  32'(e_cnt));
    chk({tag, ".done"},  32'(done),   32'(e_done));
  endtask

  task automatic run_steps(input string tag, input logic [1:0] e_gnt, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      step();
      chk_all($sformatf("%s_c%0d", tag, i), e_gnt, 1'b1, 1'b1, W'(i), 2'b00);
    end
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; len0 = '0; len1 = '0; abort = 1'b0;
    step();
    step();
    chk_all("reset", 2'b00, 1'b0, 1'b0, 4'd0, 2'b00);
    reset = 1'b0;

    // Single request, len0=3
    req = 2'b01; len0 = 4'd3;
    step();
    chk_all("single_grant", 2'b01, 1'b1, 1'b1, 4'd0, 2'b00);
    req = 2'b00;
    run_steps("single", 2'b01, 1, 3);
    step();
    chk_all("single_done", 2'b00, 1'b0, 1'b0, 4'd3, 2'b01);
    step();
    chk_all("single_idle", 2'b00, 1'b0, 1'b0, 4'd0, 2'b00);

    // Contention: last served was 0, so requester 1 goes first
    req = 2'b11; len0 = 4'd1; len1 = 4'd2;
    step();
    chk_all("cont_g1", 2'b10, 1'b1, 1'b1, 4'd0, 2'b00);
    run_steps("cont_r1", 2'b10, 1, 2);
    step();
    chk_all("cont_d1", 2'b00, 1'b0, 1'b0, 4'd2, 2'b10);
    step();
    chk_all("cont_idle1", 2'b00, 1'b0, 1'b0, 4'd0, 2'b00);
    step();
    chk_all("cont_g0", 2'b01, 1'b1, 1'b1, 4'd0, 2'b00);
    run_steps("cont_r0", 2'b01, 1, 1);
    step();
    chk_all("cont_d0", 2'b00, 1'b0, 1'b0, 4'd1, 2'b01);
    step();
    chk_all("cont_idle0", 2'b00, 1'b0, 1'b0, 4'd0, 2'b00);
    step();
    chk_all("cont_g1b", 2'b10, 1'b1, 1'b1, 4'd0, 2'b00);
    // Dropping req mid-run must not disturb the run
    req = 2'b00;
    run_steps("cont_r1b", 2'b10, 1, 2);
    step();
    chk_all("cont_d1b", 2'b00, 1'b0, 1'b0, 4'd2, 2'b10);
    step();
    chk_all("cont_idle1b", 2'b00, 1'b0, 1'b0, 4'd0, 2'b00);

    // Boundary: full-range target, no wrap
    req = 2'b10; len1 = 4'd15;
    step();
    chk_all("max_grant", 2'b10, 1'b1, 1'b1, 4'd0, 2'b00);
    req = 2'b00;
    run_steps("max", 2'b10, 1, 15);
    step();
    chk_all("max_done", 2'b00, 1'b0, 1'b0, 4'd15, 2'b10);
    step();
    chk_all("max_idle", 2'b00, 1'b0, 1'b0, 4'd0, 2'b00);

    // Boundary: zero target is a single RUN cycle
    req = 2'b01; len0 = 4'd0;
    step();
    chk_all("zero_grant", 2'b01, 1'b1, 1'b1, 4'd0, 2'b00);
    req = 2'b00;
    step();
    chk_all("zero_done", 2'b00, 1'b0, 1'b0, 4'd0, 2'b01);
    step();
    chk_all("zero_idle", 2'b00, 1'b0, 1'b0, 4'd0, 2'b00);

    // Abort at count=4 with requester 1 pending
    req = 2'b01; len0 = 4'd8; len1 = 4'd1;
    step();
    chk_all("ab_grant", 2'b01, 1'b1, 1'b1, 4'd0, 2'b00);
    req = 2'b10;
    run_steps("ab", 2'b01, 1, 4);
    abort = 1'b1;
    step();
    chk_all("ab_idle", 2'b00, 1'b0, 1'b0, 4'd0, 2'b00);
    chk("ab_state", 32'(dbg_state), 32'(ST_IDLE));
    abort = 1'b0;
    step();
    chk_all("ab_next_grant", 2'b10, 1'b1, 1'b1, 4'd0, 2'b00);
    req = 2'b00;
    run_steps("ab_next", 2'b10, 1, 1);
    step();
    chk_all("ab_next_done", 2'b00, 1'b0, 1'b0, 4'd1, 2'b10);

    // Abort outside RUN is ignored
    abort = 1'b1;
    step();
    chk_all("ab_in_idle", 2'b00, 1'b0, 1'b0, 4'd0, 2'b00);
    abort = 1'b0;

    // Abort wins over terminal count in the same cycle
    req = 2'b10; len1 = 4'd2;
    step();
    req = 2'b00;
    run_steps("abtc", 2'b10, 1, 2);
    abort = 1'b1;
    step();
    chk_all("abtc_idle", 2'b00, 1'b0, 1'b0, 4'd0, 2'b00);
    abort = 1'b0;

    // Reset mid-run: last served becomes 0, but reset must favour 0 again
    req = 2'b01; len0 = 4'd9;
    step();
    req = 2'b00;
    run_steps("rst", 2'b01, 0 + 1, 5);
    reset = 1'b1;
    step();
    chk_all("rst_mid", 2'b00, 1'b0, 1'b0, 4'd0, 2'b00);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0; req = 2'b11; len0 = 4'd3; len1 = 4'd7;
    step();
    chk_all("rst_grant", 2'b01, 1'b1, 1'b1, 4'd0, 2'b00);

    // Stability: len0 changes after grant do not move the target
    req = 2'b00; len0 = 4'd9;
    run_steps("stab", 2'b01, 1, 3);
    step();
    chk_all("stab_done", 2'b00, 1'b0, 1'b0, 4'd3, 2'b01);
    step();
    chk_all("stab_idle", 2'b00, 1'b0, 1'b0, 4'd0, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
